// File: rtl/sssp_pkg.sv
// sssp_pkg: shared line/edge layout, FSM encoding and slot unpacking helper.
package sssp_pkg;

   localparam int EDGES_PER_LINE = 4;
   localparam int EDGE_SLOT_BITS = 128;
   localparam int LINE_BITS      = EDGES_PER_LINE * EDGE_SLOT_BITS;
   localparam int FIELD_BITS     = 32;
   localparam int SRC_OFF        = 0;
   localparam int DST_OFF        = 32;
   localparam int WEIGHT_OFF     = 64;

   typedef struct packed {
      logic [FIELD_BITS-1:0] src;
      logic [FIELD_BITS-1:0] dst;
      logic [FIELD_BITS-1:0] weight;
   } t_edge;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } t_state;

   // The top 32 bits of each slot are reserved and never extracted.
   function automatic t_edge unpack_edge(input logic [LINE_BITS-1:0] line, input logic [1:0] slot);
      t_edge e;
      e.src    = line[EDGE_SLOT_BITS*slot + SRC_OFF    +: FIELD_BITS];
      e.dst    = line[EDGE_SLOT_BITS*slot + DST_OFF    +: FIELD_BITS];
      e.weight = line[EDGE_SLOT_BITS*slot + WEIGHT_OFF +: FIELD_BITS];
      return e;
   endfunction

endpackage

// File: rtl/sssp_line_fifo.sv
// sssp_line_fifo: synchronous cache-line FIFO; read data is the head entry, writes to a full FIFO are dropped.
module sssp_line_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 512
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       clear,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_data,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_data,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr, rd_ptr;
   logic             wr_ok, rd_ok;

   assign full    = count == (AW+1)'(DEPTH);
   assign empty   = count == '0;
   assign wr_ok   = wr_en && !full;
   assign rd_ok   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk)
      if (wr_ok) mem[wr_ptr] <= wr_data;

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_ok);
         rd_ptr <= rd_ptr + AW'(rd_ok);
         count  <= count + (AW+1)'(wr_ok) - (AW+1)'(rd_ok);
      end
   end

endmodule

// File: rtl/edge_stream_unpacker.sv
// edge_stream_unpacker: buffers DMA cache lines and hands out their packed edges one per cycle.
module edge_stream_unpacker
   import sssp_pkg::*;
#(
   parameter int FIFO_DEPTH  = 16,
   parameter int AFULL_SLACK = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [31:0]          n_edges,
   input  logic [LINE_BITS-1:0] in_line,
   input  logic                 in_valid,
   output logic [31:0]          edge_src,
   output logic [31:0]          edge_dst,
   output logic [31:0]          edge_weight,
   output logic                 edge_valid,
   input  logic                 edge_ready,
   output logic                 buf_almost_full,
   output logic                 overflow,
   output logic                 done,
   output logic [1:0]           state_out
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   t_state               state, state_nx;
   logic [31:0]          n_reg, edge_cnt;
   logic [1:0]           slot;
   logic [LINE_BITS-1:0] line_q, fifo_data;
   logic [CW-1:0]        fifo_count;
   logic                 hold, fifo_full, fifo_empty;
   logic                 run, accept, last, retire, pop, wr, clear, begin_pass;
   t_edge                e;

   assign run        = state == RUN;
   assign begin_pass = state == IDLE && start;
   assign accept     = run && hold && edge_ready;
   assign last       = accept && edge_cnt + 32'd1 == n_reg;
   assign retire     = accept && (slot == 2'd3 || last);
   // Refill the holding register on retire so line boundaries cost no bubble.
   assign pop        = run && !fifo_empty && (!hold || retire) && !last;
   assign wr         = run && in_valid;
   assign clear      = begin_pass || state == FINISH;

   sssp_line_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(LINE_BITS)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .clear   (clear),
      .wr_en   (wr),
      .wr_data (in_line),
      .rd_en   (pop),
      .rd_data (fifo_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   assign e           = unpack_edge(line_q, slot);
   assign edge_src    = e.src;
   assign edge_dst    = e.dst;
   assign edge_weight = e.weight;
   assign edge_valid  = run && hold;
   assign done        = state == FINISH;
   assign state_out   = state;

   always_comb begin
      state_nx = state;
      if (begin_pass) state_nx = n_edges == 32'd0 ? FINISH : RUN;
      else if (last) state_nx = FINISH;
      else if (state == FINISH) state_nx = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         n_reg           <= '0;
         edge_cnt        <= '0;
         slot            <= '0;
         line_q          <= '0;
         hold            <= 1'b0;
         overflow        <= 1'b0;
         buf_almost_full <= 1'b0;
      end else begin
         state           <= state_nx;
         buf_almost_full <= fifo_count >= CW'(FIFO_DEPTH - AFULL_SLACK);
         if (begin_pass) begin
            n_reg    <= n_edges;
            edge_cnt <= '0;
            slot     <= '0;
            hold     <= 1'b0;
            overflow <= 1'b0;
         end else begin
            if (wr && fifo_full) overflow <= 1'b1;
            if (accept) begin
               edge_cnt <= edge_cnt + 32'd1;
               slot     <= retire ? 2'd0 : slot + 2'd1;
            end
            if (pop) line_q <= fifo_data;
            hold <= pop || (hold && !retire);
         end
      end
   end

endmodule

// File: tb/tb_edge_stream_unpacker.sv
// tb_edge_stream_unpacker: directed self-checking bench for edge_stream_unpacker.
module tb_edge_stream_unpacker;

   logic         clk = 1'b0;
   logic         reset, start, in_valid, edge_ready;
   logic [31:0]  n_edges;
   logic [511:0] in_line;
   logic [31:0]  edge_src, edge_dst, edge_weight;
   logic         edge_valid, buf_almost_full, overflow, done;
   logic [1:0]   state_out;
   int           checks = 0;
   int           failures = 0;

   always #5 clk = ~clk;

   edge_stream_unpacker dut (
      .clk             (clk),
      .reset           (reset),
      .start           (start),
      .n_edges         (n_edges),
      .in_line         (in_line),
      .in_valid        (in_valid),
      .edge_src        (edge_src),
      .edge_dst        (edge_dst),
      .edge_weight     (edge_weight),
      .edge_valid      (edge_valid),
      .edge_ready      (edge_ready),
      .buf_almost_full (buf_almost_full),
      .overflow        (overflow),
      .done            (done),
      .state_out       (state_out)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Edge with source s carries dst s+1 and weight 10*s.
   task automatic check_edge(input string tag, input int s);
      chk({tag, "_valid"}, {31'd0, edge_valid}, 32'd1);
      chk({tag, "_src"}, edge_src, s);
      chk({tag, "_dst"}, edge_dst, s + 1);
      chk({tag, "_weight"}, edge_weight, 10 * s);
   endtask

   function automatic logic [511:0] mk_line(input int base);
      logic [511:0] l;
      for (int k = 0; k < 4; k++) begin
         l[128*k      +: 32] = base + k;
         l[128*k + 32 +: 32] = base + k + 1;
         l[128*k + 64 +: 32] = 10 * (base + k);
         l[128*k + 96 +: 32] = 32'hDEAD0000 + k;
      end
      return l;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic begin_pass(input int n);
      start   = 1'b1;
      n_edges = n;
      tick();
      start   = 1'b0;
   endtask

   initial begin
      int dc, acc, c;
      logic seen_done;
      reset = 1'b1; start = 1'b0; in_valid = 1'b0; edge_ready = 1'b0;
      n_edges = '0; in_line = '0;
      tick(); tick();
      reset = 1'b0;
      #1;
      chk("rst_valid", {31'd0, edge_valid}, 0);
      chk("rst_done", {31'd0, done}, 0);
      chk("rst_ovf", {31'd0, overflow}, 0);
      chk("rst_afull", {31'd0, buf_almost_full}, 0);
      chk("rst_state", {30'd0, state_out}, 0);
      chk("rst_src", edge_src, 0);

      // Two full lines, 8 edges at full rate
      begin_pass(8);
      chk("t1_state_run", {30'd0, state_out}, 1);
      in_valid = 1'b1; in_line = mk_line(0);
      tick();
      in_line = mk_line(4);
      #1;
      chk("t1_latency_t1", {31'd0, edge_valid}, 0);
      tick();
      in_valid = 1'b0; edge_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         check_edge("t1_edge", i);
         tick();
      end
      chk("t1_done", {31'd0, done}, 1);
      chk("t1_fin_valid", {31'd0, edge_valid}, 0);
      chk("t1_state_fin", {30'd0, state_out}, 2);
      tick();
      chk("t1_done_once", {31'd0, done}, 0);
      chk("t1_state_idle", {30'd0, state_out}, 0);

      // Partial last line: slots 2,3 of the second line are dropped
      begin_pass(6);
      in_valid = 1'b1; in_line = mk_line(100);
      tick();
      in_line = mk_line(104);
      tick();
      in_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         check_edge("t2_edge", 100 + i);
         tick();
      end
      dc = 0;
      for (int i = 0; i < 4; i++) begin
         dc += int'(done);
         chk("t2_no_extra", {31'd0, edge_valid}, 0);
         tick();
      end
      chk("t2_done_count", dc, 1);
      chk("t2_state_idle", {30'd0, state_out}, 0);

      // Stalled consumer: outputs hold until accepted
      edge_ready = 1'b0;
      begin_pass(4);
      in_valid = 1'b1; in_line = mk_line(200);
      tick();
      in_valid = 1'b0;
      acc = 0; c = 0; seen_done = 1'b0;
      while (c < 40 && !seen_done) begin
         edge_ready = (c % 3 == 0);
         #1;
         if (done) seen_done = 1'b1;
         if (edge_valid) begin
            check_edge("t3_edge", 200 + acc);
            if (edge_ready) acc++;
         end
         c++;
         tick();
      end
      chk("t3_accepts", acc, 4);
      chk("t3_done_seen", {31'd0, seen_done}, 1);

      // Fill: one line sits in the holding register, 16 in the FIFO, 18th is dropped
      edge_ready = 1'b0;
      begin_pass(64);
      for (int j = 0; j < 18; j++) begin
         in_valid = 1'b1; in_line = mk_line(1000 + 4 * j);
         tick();
         if (j == 4) chk("t4_afull_low", {31'd0, buf_almost_full}, 0);
         if (j == 16) chk("t4_no_ovf_yet", {31'd0, overflow}, 0);
      end
      in_valid = 1'b0;
      chk("t4_ovf", {31'd0, overflow}, 1);
      chk("t4_afull", {31'd0, buf_almost_full}, 1);
      edge_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         check_edge("t4_drain", 1000 + i);
         tick();
      end
      chk("t4_done", {31'd0, done}, 1);
      chk("t4_ovf_sticky", {31'd0, overflow}, 1);
      tick(); tick();
      chk("t4_afull_clear", {31'd0, buf_almost_full}, 0);

      // Empty pass
      begin_pass(0);
      chk("t5_done", {31'd0, done}, 1);
      chk("t5_valid", {31'd0, edge_valid}, 0);
      chk("t5_state", {30'd0, state_out}, 2);
      chk("t5_ovf_cleared", {31'd0, overflow}, 0);
      tick();
      chk("t5_done_once", {31'd0, done}, 0);
      chk("t5_state_idle", {30'd0, state_out}, 0);
      chk("t5_valid2", {31'd0, edge_valid}, 0);

      // Reset mid-pass, then a clean pass
      edge_ready = 1'b0;
      begin_pass(64);
      for (int j = 0; j < 3; j++) begin
         in_valid = 1'b1; in_line = mk_line(400 + 4 * j);
         tick();
      end
      in_valid = 1'b0;
      tick();
      check_edge("t6_pre", 400);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("t6_valid", {31'd0, edge_valid}, 0);
      chk("t6_src", edge_src, 0);
      chk("t6_dst", edge_dst, 0);
      chk("t6_weight", edge_weight, 0);
      chk("t6_done", {31'd0, done}, 0);
      chk("t6_state", {30'd0, state_out}, 0);
      chk("t6_afull", {31'd0, buf_almost_full}, 0);
      chk("t6_ovf", {31'd0, overflow}, 0);
      begin_pass(4);
      in_valid = 1'b1; in_line = mk_line(300);
      tick();
      in_valid = 1'b0; edge_ready = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         check_edge("t6_edge", 300 + i);
         tick();
      end
      chk("t6_done_after", {31'd0, done}, 1);
      tick();
      chk("t6_state_idle", {30'd0, state_out}, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
